// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and default timing for the PLL lock supervisor
package pll_sup_pkg;
  typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL} state_t;
  localparam int REF_HZ = 74_250_000;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = REF_HZ / 1000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES = 7;
  localparam int DEF_CNT_W = 20;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit
//   clk, rst (sync, active high) ; d async input ; q synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for stable lock, then releases the system reset
//   clk_74a/rst ; pll_locked (async), retry_req (pulse, used in FAIL only)
//   pll_rst, sys_rst, ready, fail, lock_lost (sticky), retry_count (saturating)
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       clk_74a,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] retry_count
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0] attempts, attempts_n;
  logic locked_s, bump, drop;
  sync_2ff u_sync (.clk(clk_74a), .rst(rst), .d(pll_locked), .q(locked_s));
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    attempts_n = attempts;
    bump = 1'b0;
    drop = 1'b0;
    case (state)
      S_PLL_RST: if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
        state_n = S_WAIT_LOCK;
        cnt_n = '0;
      end
      // lock seen on the timeout cycle still wins over a retry
      S_WAIT_LOCK: if (locked_s) begin
        state_n = S_STABLE;
        cnt_n = '0;
      end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
        cnt_n = '0;
        if (attempts == 8'(MAX_RETRIES)) state_n = S_FAIL;
        else begin
          state_n = S_PLL_RST;
          attempts_n = attempts + 8'd1;
          bump = 1'b1;
        end
      end
      // a lock glitch restarts the wait without charging a retry
      S_STABLE: if (!locked_s) begin
        state_n = S_WAIT_LOCK;
        cnt_n = '0;
      end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
        state_n = S_RUN;
        attempts_n = '0;
        cnt_n = '0;
      end
      S_RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n = S_PLL_RST;
          drop = 1'b1;
          bump = 1'b1;
        end
      end
      S_FAIL: begin
        cnt_n = '0;
        if (retry_req) begin
          state_n = S_PLL_RST;
          attempts_n = '0;
        end
      end
      default: begin
        state_n = S_PLL_RST;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk_74a) begin
    if (rst) begin
      state <= S_PLL_RST;
      cnt <= '0;
      attempts <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready <= 1'b0;
      fail <= 1'b0;
      lock_lost <= 1'b0;
      retry_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      attempts <= attempts_n;
      pll_rst <= state_n == S_PLL_RST || state_n == S_FAIL;
      sys_rst <= state_n != S_RUN;
      ready <= state_n == S_RUN;
      fail <= state_n == S_FAIL;
      lock_lost <= lock_lost | drop;
      retry_count <= retry_count + 8'(bump && retry_count != 8'hff);
    end
  end
endmodule
